// File: rtl/decim_tick_sequencer.sv
// rtl/decim_tick_sequencer.sv - decimation tick sequencer for the downsampler keep-enable
// Emits a one-cycle tick every R clocks, continuously or for a burst of K ticks.
module decim_tick_sequencer #(
  parameter int CNT_WIDTH   = 16,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CNT_WIDTH-1:0]   cfg_ratio,
  input  logic [BURST_WIDTH-1:0] cfg_burst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   tick,
  output logic                   busy,
  output logic                   done,
  output logic [BURST_WIDTH-1:0] ticks_left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   ratio_q;
  logic [BURST_WIDTH-1:0] burst_q;
  logic [CNT_WIDTH-1:0]   cnt;

  logic                   cfg_fire;
  logic [CNT_WIDTH-1:0]   ratio_in;
  logic [CNT_WIDTH-1:0]   ratio_eff;
  logic [BURST_WIDTH-1:0] burst_eff;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic                   run_tick;
  logic                   run_last;
  logic                   start_tick;
  logic                   start_last;
  logic                   launch;

  // A config accepted on the same edge as start must govern that run, so the
  // launch path looks through the handshake instead of the stored registers.
  always_comb begin
    cfg_fire   = cfg_valid & cfg_ready;
    ratio_in   = (cfg_ratio == '0) ? CNT_ONE : cfg_ratio;
    ratio_eff  = cfg_fire ? ratio_in : ratio_q;
    burst_eff  = cfg_fire ? cfg_burst : burst_q;
    cnt_next   = (cnt == ratio_q - CNT_ONE) ? '0 : cnt + CNT_ONE;
    run_tick   = (cnt_next == ratio_q - CNT_ONE);
    run_last   = run_tick && (burst_q != '0) && (ticks_left == BURST_ONE);
    start_tick = (ratio_eff == CNT_ONE);
    start_last = start_tick && (burst_eff == BURST_ONE);
    launch     = start && !abort && (state != RUN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      ratio_q    <= CNT_ONE;
      burst_q    <= '0;
      cnt        <= '0;
      ticks_left <= '0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (cfg_fire) begin
        ratio_q <= ratio_in;
        burst_q <= cfg_burst;
      end
      case (state)
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            cnt        <= '0;
            ticks_left <= '0;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
          end else begin
            cnt <= cnt_next;
            if (run_tick) begin
              tick <= 1'b1;
              if (burst_q != '0) ticks_left <= ticks_left - BURST_ONE;
            end
            if (run_last) begin
              state     <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              cfg_ready <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE share the launch path; DONE otherwise falls back to IDLE.
          if (launch) begin
            cnt  <= '0;
            tick <= start_tick;
            if (start_last) begin
              state      <= DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              ticks_left <= '0;
              cfg_ready  <= 1'b1;
            end else begin
              state      <= RUN;
              busy       <= 1'b1;
              cfg_ready  <= 1'b0;
              ticks_left <= (start_tick && burst_eff != '0) ? burst_eff - BURST_ONE : burst_eff;
            end
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decim_tick_sequencer.sv
// tb/tb_decim_tick_sequencer.sv - scoreboard bench for decim_tick_sequencer
// Stimulus queues expected tick events; a negedge monitor pops and compares them.
module tb_decim_tick_sequencer;

  localparam int CW = 16;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ratio = '0;
  logic [BW-1:0] cfg_burst = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tick;
  logic          busy;
  logic          done;
  logic [BW-1:0] ticks_left;

  decim_tick_sequencer #(.CNT_WIDTH(CW), .BURST_WIDTH(BW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ratio  (cfg_ratio),
    .cfg_burst  (cfg_burst),
    .start      (start),
    .abort      (abort),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .ticks_left (ticks_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        done;
    logic        busy;
    logic [BW-1:0] tl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  // Expected events for a start issued in the current cycle: ticks at c+i*r.
  task automatic push_run(input int r, input int k, input int n);
    int c;
    exp_t e;
    c = cyc;
    for (int i = 1; i <= n; i++) begin
      e.cyc  = c + i * r;
      e.done = (k != 0) && (i == k);
      e.busy = !e.done;
      e.tl   = (k == 0) ? BW'(0) : BW'(k - i);
      sb.push_back(e);
    end
  endtask

  task automatic cfg(input int r, input int k);
    cfg_ratio = CW'(r);
    cfg_burst = BW'(k);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (resetn && (tick || done)) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: tick=%0b done=%0b at cycle %0d, none required", tick, done, cyc);
      end else begin
        e = sb.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("tick", {31'b0, tick}, 32'd1);
        chk("done", {31'b0, done}, {31'b0, e.done});
        chk("busy", {31'b0, busy}, {31'b0, e.busy});
        chk("ticks_left", {24'b0, ticks_left}, {24'b0, e.tl});
      end
    end
  end

  initial begin
    int c;
    int c2;
    step(2);
    chk("rst_tick", {31'b0, tick}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_cfg_ready", {31'b0, cfg_ready}, 1);
    chk("rst_ticks_left", {24'b0, ticks_left}, 0);
    resetn = 1'b1;
    step(2);

    // Default config R=1 K=0: tick every cycle until abort.
    c = cyc;
    push_run(1, 0, 6);
    pulse_start();
    chk("t1_busy", {31'b0, busy}, 1);
    chk("t1_ticks_left", {24'b0, ticks_left}, 0);
    goto(c + 6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t1_busy_after_abort", {31'b0, busy}, 0);
    step(3);

    // R=4 K=3 burst.
    cfg(4, 3);
    step(2);
    c = cyc;
    push_run(4, 3, 3);
    pulse_start();
    chk("t2_ticks_left_load", {24'b0, ticks_left}, 3);
    chk("t2_cfg_ready_run", {31'b0, cfg_ready}, 0);
    goto(c + 12);
    chk("t2_cfg_ready_done", {31'b0, cfg_ready}, 1);
    step();
    chk("t2_idle_cfg_ready", {31'b0, cfg_ready}, 1);
    chk("t2_idle_busy", {31'b0, busy}, 0);
    chk("t2_idle_done", {31'b0, done}, 0);
    step(2);

    // R=5 continuous, abort coincident with second terminal count.
    cfg(5, 0);
    c = cyc;
    push_run(5, 0, 1);
    pulse_start();
    goto(c + 9);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t3_busy", {31'b0, busy}, 0);
    chk("t3_ticks_left", {24'b0, ticks_left}, 0);
    step(8);

    // R=3 K=4 with a new config held pending through the run.
    cfg(3, 4);
    c = cyc;
    push_run(3, 4, 4);
    pulse_start();
    cfg_ratio = CW'(7);
    cfg_burst = BW'(2);
    cfg_valid = 1'b1;
    chk("t4_cfg_ready_c1", {31'b0, cfg_ready}, 0);
    goto(c + 7);
    chk("t4_cfg_ready_c7", {31'b0, cfg_ready}, 0);
    goto(c + 12);
    chk("t4_cfg_ready_done", {31'b0, cfg_ready}, 1);
    step();
    cfg_valid = 1'b0;
    cfg_ratio = CW'(3);
    cfg_burst = BW'(9);
    c2 = cyc;
    push_run(7, 2, 2);
    pulse_start();
    goto(c2 + 16);

    // Config and start in the same IDLE cycle.
    c = cyc;
    cfg_ratio = CW'(2);
    cfg_burst = BW'(2);
    cfg_valid = 1'b1;
    push_run(2, 2, 2);
    pulse_start();
    cfg_valid = 1'b0;
    goto(c + 6);

    // Ratio 0 behaves as 1.
    cfg(0, 2);
    c = cyc;
    push_run(1, 2, 2);
    pulse_start();
    goto(c + 4);

    // Asynchronous reset mid-run restores defaults.
    cfg(8, 5);
    c = cyc;
    push_run(8, 5, 1);
    pulse_start();
    goto(c + 10);
    chk("t6_ticks_left_mid", {24'b0, ticks_left}, 4);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_tick", {31'b0, tick}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_done", {31'b0, done}, 0);
    chk("arst_cfg_ready", {31'b0, cfg_ready}, 1);
    chk("arst_ticks_left", {24'b0, ticks_left}, 0);
    step(2);
    resetn = 1'b1;
    step(2);
    c = cyc;
    push_run(1, 0, 3);
    pulse_start();
    goto(c + 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step(4);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/decim_tick_sequencer.md
Name: decim_tick_sequencer

Overview:
Controller that sequences the free-running up-counter datapath of the downsampling processor. It turns a programmed decimation ratio R into a one-cycle sample strobe (tick) every R clocks. It runs either continuously or for a programmed burst of K ticks, then reports completion. Configuration arrives over a valid/ready handshake from the control plane. The tick drives the downsampler's sample-keep enable.

Parameters:
CNT_WIDTH, 16, width of the ratio field and the internal prescale counter
BURST_WIDTH, 8, width of the burst-length field and the tick-remaining counter

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  asynchronous, active-low reset
cfg_valid  input  1  configuration word valid
cfg_ready  output  1  sequencer can accept configuration
cfg_ratio  input  CNT_WIDTH  decimation ratio R; 0 is treated as 1
cfg_burst  input  BURST_WIDTH  burst length K; 0 = continuous
start  input  1  single-cycle request to begin a run
abort  input  1  terminate the current run immediately
tick  output  1  registered sample strobe, one cycle wide
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when a burst completes normally
ticks_left  output  BURST_WIDTH  ticks remaining in the current burst; 0 in continuous mode

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, prescale counter=0, ticks_left=0.
  - tick=0, busy=0, done=0, cfg_ready=1.
  - Stored config: R=1, K=0.
- States: IDLE, RUN, DONE.
- cfg_ready = 1 in IDLE and DONE, 0 in RUN.
- Config handshake:
  - Transfer occurs on an edge where cfg_valid & cfg_ready are both high; R and K are latched.
  - cfg_ratio=0 is stored as 1.
  - During RUN, cfg_valid is held off by cfg_ready=0. The running config is never changed mid-run.
- IDLE -> RUN:
  - Trigger: start=1 at an edge.
  - Prescale counter cleared to 0. ticks_left loaded with K.
  - busy=1 from the next cycle.
  - If cfg_valid and start are in the same IDLE cycle, the new config is accepted and that run uses it.
- RUN tick generation:
  - The prescale counter increments each cycle and wraps from R-1 to 0.
  - tick=1 for the cycle after the edge at which the counter equals R-1.
  - If start is high in cycle c, ticks are high in cycles c+R, c+2R, ...
  - R=1: tick is high every cycle from c+1.
- Burst bookkeeping:
  - When K≠0, ticks_left decrements with each tick.
  - The edge issuing the K-th tick moves to DONE. ticks_left=0.
  - K=0: never leaves RUN except by abort; ticks_left stays 0.
- DONE:
  - done=1 for exactly one cycle, coincident with the final tick. busy=0 in that cycle.
  - Next edge returns to IDLE.
  - start in DONE is treated as start in IDLE and begins a new run directly.
- abort:
  - Abort at an edge in RUN -> IDLE. Counter=0, ticks_left=0.
  - No tick and no done are produced, even if terminal count coincides.
  - Abort has priority over start. Abort in IDLE/DONE has no effect beyond suppressing start.
- start while in RUN is ignored.
- Counter arithmetic:
  - Modulo 2^CNT_WIDTH, unsigned.
  - Max R = 2^CNT_WIDTH-1; the counter compare never overflows.
- Reset asserted mid-run: immediate return to reset values. No done pulse.

Test Plan:
- Reset release, no config, start pulse -> tick high every cycle from start+1 (R=1, K=0), busy=1, ticks_left=0, done never asserts.
- cfg R=4 K=3, start at cycle 10 -> ticks at cycles 14, 18, 22; ticks_left 3→2→1→0; done=1 and busy=0 at cycle 22; IDLE at cycle 23, cfg_ready=1.
- cfg R=5 K=0, start, abort at cycle start+10 -> ticks at start+5 and start+10 suppressed; busy drops; no done.
- During a run with R=3 K=4, hold cfg_valid with R=7 -> cfg_ready=0 throughout, spacing stays 3; handshake completes on the DONE cycle; next run spaced 7.
- cfg_valid (R=2 K=2) and start in the same IDLE cycle -> run uses R=2; ticks at +2 and +4; done at +4.
- cfg_ratio=0 K=2 -> behaves as R=1, ticks at +1 and +2. Assert resetn=0 asynchronously mid-run (R=8, K=5) -> outputs zero without waiting for clk; stored config returns to R=1 K=0.
